recovery_phase_sequencer: RTL
=============================

// Module: recovery_phase_sequencer
// PURPOSE
//  Owns the pipeline phase seen by the commit stage, rename logic and active list.
//  Accepts recovery requests from commit (exceptions, refetches) and from execute (branch mispredicts).
//  Sequences PHASE_COMMIT -> PHASE_RECOVER_0 -> PHASE_RECOVER_1 -> PHASE_COMMIT.
//  Meters the active-list walk-back RECOVERY_WIDTH entries per cycle.
//  Drives unableToStartRecovery back to commit so that a second recovery cannot start mid-walk.
// PARAMETERS
//  ACTIVE_LIST_ENTRY_NUM  64  active list depth; CNT_W = $clog2(ACTIVE_LIST_ENTRY_NUM)+1
//  RECOVERY_WIDTH          4  max entries flushed per PHASE_RECOVER_1 cycle
//  COMMIT_WIDTH            4  commit lanes; IDX_W = $clog2(COMMIT_WIDTH)
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      reset, asynchronous, active-high
//  cmRecoveryReq       in   1      commit stage requests recovery (toRecoveryPhase)
//  cmRefetchType       in   3      RefetchType from commit
//  cmRecoveryCause     in   ExecutionState width  cause from commit
//  cmRecoveryOpIndex   in   IDX_W  lane of the recovering op
//  exRecoveryReq       in   1      execute-stage branch mispredict
//  flushCount          in   CNT_W  active-list entries younger than the recovery point
//  storeDrainBusy      in   1      store queue still writing committed stores
//  phase               out  2      PipelinePhase: 0 COMMIT, 1 RECOVER_0, 2 RECOVER_1
//  unableToStartRecovery out 1     (phase!=COMMIT) | storeDrainBusy
//  rmtRestore          out  1      pulse in RECOVER_0: copy retirement RMT into the rename map
//  refetchValid        out  1      pulse in RECOVER_0: redirect fetch
//  refetchType         out  3      latched type; REFETCH_TYPE_BRANCH_TARGET for execute requests
//  recoveryCause       out  ExecutionState width  latched cause; EXEC_STATE_SUCCESS for execute requests
//  recoveryOpIndex     out  IDX_W  latched lane
//  flushNum            out  $clog2(RECOVERY_WIDTH+1)  entries released this cycle
//  flushValid          out  1      flushNum is valid
// BEHAVIOUR
//  Reset (asynchronous, immediate at any state):
//   - phase=COMMIT; remaining=0; all pulse outputs 0; latched fields 0.
//  In COMMIT:
//   - Start on cmRecoveryReq, or on exRecoveryReq when !unableToStartRecovery.
//   - cmRecoveryReq is already gated by commit; it wins over exRecoveryReq in the same cycle.
//   - The execute request is then dropped, because its op is younger and is squashed anyway.
//   - On start: latch type/cause/index; remaining <= flushCount; next phase = RECOVER_0.
//  RECOVER_0:
//   - Exactly one cycle; rmtRestore=1, refetchValid=1.
//   - Next phase = RECOVER_1 if remaining!=0, else COMMIT.
//  RECOVER_1:
//   - flushValid=1; flushNum = min(remaining, RECOVERY_WIDTH); remaining -= flushNum.
//   - Leave for COMMIT in the cycle where remaining <= RECOVERY_WIDTH.
//  Requests outside COMMIT: all ignored, never queued.
//  Latency and counts:
//   - Request cycle N -> RECOVER_0 at N+1.
//   - Walk takes ceil(flushCount/RECOVERY_WIDTH) cycles.
//   - Back in COMMIT at N+2+ceil(flushCount/RECOVERY_WIDTH).
//   - remaining never underflows; flushCount > ACTIVE_LIST_ENTRY_NUM is clamped to ACTIVE_LIST_ENTRY_NUM.
//   - Sum of flushNum over one recovery == latched flushCount.
//  Output timing: phase is registered; unableToStartRecovery is combinational from phase and storeDrainBusy.
// CONFIGURATION
//  RSD_RECOVERY_STATS_EN defined:
//   - adds outputs statRecoveryNum[31:0] and statRecoveryCycles[31:0].
//   - statRecoveryNum: +1 per entry to RECOVER_0. statRecoveryCycles: +1 per cycle phase!=COMMIT.
//   - Both saturate at all-ones and reset to 0.
//  RSD_RECOVERY_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package (RecoveryManagerTypes): PipelinePhase enum, RefetchType, RECOVERY_WIDTH.
//   - ExecutionState stays in its existing package.
//  One sub-module: recovery_flush_counter (remaining register, min/subtract, done flag).
//  The FSM and latches stay in the top module.
// TESTING
//  1. cmRecoveryReq, flushCount=10, WIDTH=4 -> RECOVER_0 (1 cycle), flushNum 4,4,2, COMMIT 5 cycles after request.
//  2. cmRecoveryReq, flushCount=0 -> RECOVER_0 then COMMIT directly; flushValid never 1.
//  3. cmRecoveryReq and exRecoveryReq same cycle, cmRefetchType=THIS_PC -> refetchType=THIS_PC latched.
//  4. exRecoveryReq while in RECOVER_1, or with storeDrainBusy=1 -> ignored; phase sequence unchanged.
//  5. rst asserted mid-RECOVER_1, remaining=6 -> phase=COMMIT and flushValid=0 without waiting for clk.
//     Next request after reset works normally.
//  6. RSD_RECOVERY_STATS_EN: two recoveries with flushCount 8 and 1 -> statRecoveryNum=2, statRecoveryCycles=5.

Source files
------------

// File: rtl/recovery_phase_sequencer_pkg.sv
// recovery_phase_sequencer_pkg: shared widths and enums for the recovery phase sequencer.
// Contents: RECOVERY_WIDTH, pipeline_phase_t (PipelinePhase), refetch_type_t (RefetchType),
// exec_state_t (ExecutionState encoding, only SUCCESS is referenced by the sequencer).
package recovery_phase_sequencer_pkg;
  localparam int RECOVERY_WIDTH = 4;
  localparam int EXEC_STATE_W = 4;
  typedef enum logic [1:0] {
    PHASE_COMMIT    = 2'd0,
    PHASE_RECOVER_0 = 2'd1,
    PHASE_RECOVER_1 = 2'd2
  } pipeline_phase_t;
  typedef enum logic [2:0] {
    REFETCH_TYPE_THIS_PC                = 3'd0,
    REFETCH_TYPE_NEXT_PC                = 3'd1,
    REFETCH_TYPE_STORE_NEXT_PC          = 3'd2,
    REFETCH_TYPE_BRANCH_TARGET          = 3'd3,
    REFETCH_TYPE_NEXT_PC_TO_FETCH_ENTRY = 3'd4
  } refetch_type_t;
  typedef enum logic [EXEC_STATE_W-1:0] {
    EXEC_STATE_SUCCESS      = 4'd0,
    EXEC_STATE_REFETCH_THIS = 4'd1,
    EXEC_STATE_REFETCH_NEXT = 4'd2,
    EXEC_STATE_FAULT        = 4'd3
  } exec_state_t;
endpackage

// File: rtl/recovery_flush_counter.sv
// recovery_flush_counter: meters the active-list walk-back.
// Ports: clk, rst (async, active-high); load/count capture a new walk length (clamped to ENTRY_NUM);
// step consumes flush_num entries; flush_num = min(remaining, WIDTH); done = remaining <= WIDTH;
// nonzero = remaining != 0.
module recovery_flush_counter import recovery_phase_sequencer_pkg::*; #(
  parameter int ENTRY_NUM = 64,
  parameter int WIDTH = RECOVERY_WIDTH,
  localparam int CNT_W = $clog2(ENTRY_NUM) + 1,
  localparam int FN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] count,
  output logic [FN_W-1:0]  flush_num,
  output logic             done,
  output logic             nonzero
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(ENTRY_NUM);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  logic [CNT_W-1:0] remaining;
  assign flush_num = remaining < WIDTH_C ? remaining[FN_W-1:0] : FN_W'(WIDTH);
  assign done = remaining <= WIDTH_C;
  assign nonzero = remaining != '0;
  // flush_num never exceeds remaining, so the subtraction cannot wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) remaining <= '0;
    else if (load) remaining <= count > MAX_C ? MAX_C : count;
    else if (step) remaining <= remaining - CNT_W'(flush_num);
endmodule

// File: rtl/recovery_phase_sequencer.sv
// recovery_phase_sequencer: owns the pipeline phase COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT.
// Ports: clk, rst (async, active-high); commit request (cmRecoveryReq, cmRefetchType, cmRecoveryCause,
// cmRecoveryOpIndex); execute mispredict (exRecoveryReq); flushCount; storeDrainBusy.
// Outputs: phase, unableToStartRecovery, rmtRestore/refetchValid (RECOVER_0 pulses), latched
// refetchType/recoveryCause/recoveryOpIndex, flushNum/flushValid (RECOVER_1 walk-back).
// Optional macro RSD_RECOVERY_STATS_EN adds saturating statRecoveryNum and statRecoveryCycles.
module recovery_phase_sequencer import recovery_phase_sequencer_pkg::*; #(
  parameter int ACTIVE_LIST_ENTRY_NUM = 64,
  parameter int RECOVERY_WIDTH = recovery_phase_sequencer_pkg::RECOVERY_WIDTH,
  parameter int COMMIT_WIDTH = 4,
  localparam int CNT_W = $clog2(ACTIVE_LIST_ENTRY_NUM) + 1,
  localparam int IDX_W = $clog2(COMMIT_WIDTH),
  localparam int FN_W = $clog2(RECOVERY_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmRecoveryReq,
  input  logic [2:0]              cmRefetchType,
  input  logic [EXEC_STATE_W-1:0] cmRecoveryCause,
  input  logic [IDX_W-1:0]        cmRecoveryOpIndex,
  input  logic                    exRecoveryReq,
  input  logic [CNT_W-1:0]        flushCount,
  input  logic                    storeDrainBusy,
  output logic [1:0]              phase,
  output logic                    unableToStartRecovery,
  output logic                    rmtRestore,
  output logic                    refetchValid,
  output logic [2:0]              refetchType,
  output logic [EXEC_STATE_W-1:0] recoveryCause,
  output logic [IDX_W-1:0]        recoveryOpIndex,
  output logic [FN_W-1:0]         flushNum,
`ifdef RSD_RECOVERY_STATS_EN
  output logic                    flushValid,
  output logic [31:0]             statRecoveryNum,
  output logic [31:0]             statRecoveryCycles
`else
  output logic                    flushValid
`endif
);
  pipeline_phase_t state;
  logic start, done, nonzero;
  assign phase = state;
  assign unableToStartRecovery = (state != PHASE_COMMIT) | storeDrainBusy;
  // commit requests are pre-gated by commit and win; a simultaneous execute request is squashed anyway
  assign start = (state == PHASE_COMMIT) & (cmRecoveryReq | (exRecoveryReq & ~storeDrainBusy));
  assign rmtRestore = state == PHASE_RECOVER_0;
  assign refetchValid = state == PHASE_RECOVER_0;
  assign flushValid = state == PHASE_RECOVER_1;
  recovery_flush_counter #(
    .ENTRY_NUM(ACTIVE_LIST_ENTRY_NUM),
    .WIDTH(RECOVERY_WIDTH)
  ) u_flush (
    .clk(clk),
    .rst(rst),
    .load(start),
    .step(flushValid),
    .count(flushCount),
    .flush_num(flushNum),
    .done(done),
    .nonzero(nonzero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PHASE_COMMIT;
      refetchType <= '0;
      recoveryCause <= '0;
      recoveryOpIndex <= '0;
    end else if (start) begin
      state <= PHASE_RECOVER_0;
      refetchType <= cmRecoveryReq ? cmRefetchType : REFETCH_TYPE_BRANCH_TARGET;
      recoveryCause <= cmRecoveryReq ? cmRecoveryCause : EXEC_STATE_SUCCESS;
      recoveryOpIndex <= cmRecoveryReq ? cmRecoveryOpIndex : '0;
    end else if (state == PHASE_RECOVER_0) state <= nonzero ? PHASE_RECOVER_1 : PHASE_COMMIT;
    else if (state == PHASE_RECOVER_1 && done) state <= PHASE_COMMIT;
`ifdef RSD_RECOVERY_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      statRecoveryNum <= '0;
      statRecoveryCycles <= '0;
    end else begin
      if (start && !(&statRecoveryNum)) statRecoveryNum <= statRecoveryNum + 32'd1;
      if (state != PHASE_COMMIT && !(&statRecoveryCycles)) statRecoveryCycles <= statRecoveryCycles + 32'd1;
    end
`endif
endmodule
